// File: rtl/dct_idct_link_pkg.sv
// Shared types and helpers for the DCT -> IDCT coefficient link.
package dct_idct_link_pkg;

  typedef enum logic [1:0] {
    BLK_IDLE    = 2'd0,
    BLK_OFFER   = 2'd1,
    BLK_RELEASE = 2'd2
  } blk_state_t;

  localparam int unsigned DEFAULT_BLOCK_SIZE = 64;

  // Scaled word plus a flag telling whether it was clamped.
  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } scale_res_t;

  // Number of bits needed to index n words (at least 1).
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Round (half up), arithmetic shift, then clamp to a signed out_bits range.
  // Wide intermediate so the rounding add can never wrap.
  function automatic scale_res_t scale_word(input logic signed [63:0] x,
                                            input int unsigned        shift,
                                            input logic               round_en,
                                            input int unsigned        out_bits);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    scale_res_t         r;
    t = x;
    if (round_en && shift > 0) t = t + (64'sd1 <<< (shift - 1));
    t  = t >>> shift;
    hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_bits - 1));
    r.sat = 1'b0;
    r.val = t;
    if (t > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (t < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dct_idct_link_coef_bank.sv
// One block of coefficient storage: single write port, combinational read port.
module coef_bank
  import dct_idct_link_pkg::*;
#(
  parameter int unsigned Width     = 32,
  parameter int unsigned BlockSize = DEFAULT_BLOCK_SIZE
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [idx_w(BlockSize)-1:0]    waddr,
  input  logic [Width-1:0]               wdata,
  input  logic [idx_w(BlockSize)-1:0]    raddr,
  output logic [Width-1:0]               rdata_c
);

  logic [Width-1:0] mem [BlockSize];

  // Storage needs no reset: the full flags in the parent qualify every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/dct_idct_link.sv
// Captures DCT coefficient bursts into a ping-pong buffer, rescales them and
// replays each block to the IDCT through its start/reading handshake.
module dct_idct_link
  import dct_idct_link_pkg::*;
#(
  parameter int unsigned BitWidth  = 31,
  parameter int unsigned BlockSize = DEFAULT_BLOCK_SIZE,
  parameter int unsigned Shift     = 16,
  parameter int unsigned RoundEn   = 1,
  parameter int unsigned OutBits   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BitWidth:0] din,
  output logic              out_start,
  input  logic              out_reading,
  output logic [BitWidth:0] dout,
  output logic              blk_drop,
  output logic              sat_hit,
  output logic [15:0]       blk_cnt
);

  localparam int unsigned     W       = BitWidth + 1;
  localparam int unsigned     IdxW    = idx_w(BlockSize);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BlockSize - 1);

  // Capture side
  logic            prev_valid;
  logic            wr_on;
  logic            wr_bank;
  logic [IdxW-1:0] wr_idx;
  logic            first_c;
  logic            wr_en_c;
  logic [IdxW-1:0] widx_c;
  logic            fill_c;

  // Read side
  blk_state_t      state;
  logic            rd_bank;
  logic [IdxW-1:0] rd_idx;
  logic [IdxW-1:0] raddr_c;
  logic [W-1:0]    rword_c;

  logic [1:0]      full;
  logic [1:0]      set_c;
  logic [1:0]      clr_c;

  scale_res_t      scl_c;
  logic [W-1:0]    wdata_c;
  logic [1:0]      we_c;
  logic [W-1:0]    rdata_c [2];

  assign scl_c   = scale_word(64'($signed(din)), Shift, RoundEn != 0, OutBits);
  assign wdata_c = W'(scl_c.val);

  // Decide whether this cycle writes a word, and where.
  always_comb begin
    first_c = in_valid && !prev_valid;
    wr_en_c = in_valid && (first_c ? !full[wr_bank] : wr_on);
    widx_c  = first_c ? '0 : wr_idx;
    fill_c  = wr_en_c && (widx_c == LastIdx);
  end

  assign we_c = {wr_en_c & wr_bank, wr_en_c & ~wr_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    coef_bank #(
      .Width    (W),
      .BlockSize(BlockSize)
    ) u_bank (
      .clk    (clk),
      .we     (we_c[b]),
      .waddr  (widx_c),
      .wdata  (wdata_c),
      .raddr  (raddr_c),
      .rdata_c(rdata_c[b])
    );
  end

  // Burst tracking: write index, bank toggle, drop and saturation pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_valid <= 1'b0;
      wr_on      <= 1'b0;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      blk_drop   <= 1'b0;
      sat_hit    <= 1'b0;
    end else begin
      prev_valid <= in_valid;
      blk_drop   <= 1'b0;
      sat_hit    <= wr_en_c && scl_c.sat;
      if (wr_en_c) begin
        if (fill_c) begin
          wr_on   <= 1'b0;
          wr_bank <= ~wr_bank;
          wr_idx  <= '0;
        end else begin
          wr_on  <= 1'b1;
          wr_idx <= IdxW'(widx_c + 1'b1);
        end
      end else if (first_c) begin
        // Target bank still occupied: the whole burst is discarded.
        wr_on    <= 1'b0;
        blk_drop <= 1'b1;
      end else if (!in_valid) begin
        wr_on <= 1'b0;
        if (prev_valid && wr_on) blk_drop <= 1'b1;
      end
    end
  end

  // Read address: word 0 while waiting, the next word while offering.
  always_comb begin
    raddr_c = (state == BLK_OFFER) ? IdxW'(rd_idx + 1'b1) : '0;
    rword_c = rd_bank ? rdata_c[1] : rdata_c[0];
    set_c   = fill_c ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    clr_c   = (state == BLK_RELEASE) ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  end

  // Bank occupancy; a fill and a release on opposite banks both take effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) full <= 2'b00;
    else       full <= (full | set_c) & ~clr_c;
  end

  // Read FSM replaying full banks to the IDCT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BLK_IDLE;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      dout      <= '0;
      out_start <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      case (state)
        BLK_IDLE: begin
          if (full[rd_bank]) begin
            dout      <= rword_c;
            out_start <= 1'b1;
            rd_idx    <= '0;
            state     <= BLK_OFFER;
          end
        end
        BLK_OFFER: begin
          if (out_reading) begin
            if (rd_idx == LastIdx) begin
              out_start <= 1'b0;
              state     <= BLK_RELEASE;
            end else begin
              rd_idx <= IdxW'(rd_idx + 1'b1);
              dout   <= rword_c;
            end
          end
        end
        BLK_RELEASE: begin
          rd_bank <= ~rd_bank;
          blk_cnt <= blk_cnt + 16'd1;
          state   <= BLK_IDLE;
        end
        default: begin
          out_start <= 1'b0;
          state     <= BLK_IDLE;
        end
      endcase
    end
  end

endmodule
